// File: rtl/pico_bus_arbiter2_if.sv
// PicoRV32 native memory bus link: valid/ready handshake with address,
// write data, byte strobes and read data.
interface pico_bus_arbiter2_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/pico_bus_arbiter2.sv
// Two-master round-robin arbiter for one PicoRV32 native-bus slave, with
// grant held per transaction and a timeout that completes silent accesses.
module pico_bus_arbiter2 #(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    pico_bus_arbiter2_if.slave         m0,
    pico_bus_arbiter2_if.slave         m1,
    pico_bus_arbiter2_if.master        s,
    output logic [1:0]                 gnt,
    output logic                       timeout_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        sel1;
    logic        granted;
    logic        g_valid;
    logic        o_valid;
    logic        to_hit;
    logic        done;
    logic [31:0] rdata_g;

    always_comb begin
        sel1    = (state_q == GNT1);
        granted = (state_q != IDLE);
        g_valid = sel1 ? m1.valid : m0.valid;
        o_valid = sel1 ? m0.valid : m1.valid;
        to_hit  = (TIMEOUT != 0) && (cnt_q == TMAX);

        s.valid = 1'b0;
        s.addr  = '0;
        s.wdata = '0;
        s.wstrb = '0;
        done    = 1'b0;
        rdata_g = '0;

        if (granted) begin
            s.valid = g_valid & ~to_hit;
            s.addr  = sel1 ? m1.addr  : m0.addr;
            s.wdata = sel1 ? m1.wdata : m0.wdata;
            s.wstrb = sel1 ? m1.wstrb : m0.wstrb;
            done    = g_valid & (to_hit | s.ready);
            if (done) begin
                rdata_g = to_hit ? ERR_RDATA : s.rdata;
            end
        end

        m0.ready    = done & ~sel1;
        m1.ready    = done & sel1;
        m0.rdata    = sel1 ? '0 : rdata_g;
        m1.rdata    = sel1 ? rdata_g : '0;
        timeout_err = done & to_hit;
        gnt         = {state_q == GNT1, state_q == GNT0};
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (m0.valid && m1.valid) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0.valid) begin
                    state_d = GNT0;
                end else if (m1.valid) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (done) begin
                    // Hand straight to the waiting master: no dead cycle.
                    last_d  = sel1;
                    state_d = o_valid ? (sel1 ? GNT0 : GNT1) : IDLE;
                end else if (!g_valid) begin
                    state_d = IDLE;
                end else if (cnt_q != TMAX) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pico_bus_arbiter2.sv
// Directed testbench for pico_bus_arbiter2: handshake, round-robin,
// back-to-back alternation, timeout, slave stall and async reset.
module tb_pico_bus_arbiter2;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  gnt;
    logic        timeout_err;
    logic        slave_en;
    logic [31:0] slave_rdata;
    int          checks = 0;
    int          errors = 0;

    pico_bus_arbiter2_if m0_if ();
    pico_bus_arbiter2_if m1_if ();
    pico_bus_arbiter2_if s_if ();

    pico_bus_arbiter2 dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0          (m0_if),
        .m1          (m1_if),
        .s           (s_if),
        .gnt         (gnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    assign s_if.ready = s_if.valid & slave_en;
    assign s_if.rdata = slave_rdata;

    // {gnt, s_valid, m0_ready, m1_ready, timeout_err}
    function automatic logic [5:0] st();
        return {gnt, s_if.valid, m0_if.ready, m1_if.ready, timeout_err};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn      = 1'b0;
        m0_if.valid = 1'b0;
        m0_if.addr  = '0;
        m0_if.wdata = '0;
        m0_if.wstrb = '0;
        m1_if.valid = 1'b0;
        m1_if.addr  = '0;
        m1_if.wdata = '0;
        m1_if.wstrb = '0;
        slave_en    = 1'b1;
        slave_rdata = 32'h5555_AAAA;
        tick();
        tick();
        #1;
        checks++;
        if (st() !== 6'b0) begin
            errors++;
            $display("FAIL reset_status: got %b want %b", st(), 6'b0);
        end
        checks++;
        if ({s_if.addr, s_if.wdata, s_if.wstrb, m0_if.rdata, m1_if.rdata}
            !== 132'b0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                {s_if.addr, s_if.wdata, s_if.wstrb, m0_if.rdata, m1_if.rdata});
        end
        resetn = 1'b1;
    endtask

    task automatic test_single_write();
        tick();
        m0_if.valid = 1'b1;
        m0_if.addr  = 32'h8000_0008;
        m0_if.wdata = 32'h0000_00A5;
        m0_if.wstrb = 4'hF;
        #1;
        checks++;
        if (st() !== 6'b00_0000) begin
            errors++;
            $display("FAIL t1_idle: got %b want %b", st(), 6'b00_0000);
        end
        tick();
        #1;
        checks++;
        if (st() !== 6'b01_1100) begin
            errors++;
            $display("FAIL t1_grant: got %b want %b", st(), 6'b01_1100);
        end
        checks++;
        if ({s_if.addr, s_if.wdata, s_if.wstrb}
            !== {32'h8000_0008, 32'h0000_00A5, 4'hF}) begin
            errors++;
            $display("FAIL t1_bus: got %h want %h",
                {s_if.addr, s_if.wdata, s_if.wstrb},
                {32'h8000_0008, 32'h0000_00A5, 4'hF});
        end
        tick();
        m0_if.valid = 1'b0;
        #1;
        checks++;
        if (st() !== 6'b00_0000) begin
            errors++;
            $display("FAIL t1_release: got %b want %b", st(), 6'b00_0000);
        end
    endtask

    task automatic test_tie_break();
        slave_rdata = 32'h1234_5678;
        tick();
        m0_if.valid = 1'b1;
        m0_if.addr  = 32'h8000_0000;
        m0_if.wstrb = 4'h0;
        m1_if.valid = 1'b1;
        m1_if.addr  = 32'h8000_0004;
        m1_if.wstrb = 4'h0;
        tick();
        #1;
        checks++;
        if (st() !== 6'b01_1100) begin
            errors++;
            $display("FAIL t2_m0_first: got %b want %b", st(), 6'b01_1100);
        end
        tick();
        m0_if.valid = 1'b0;
        #1;
        checks++;
        if (st() !== 6'b10_1010) begin
            errors++;
            $display("FAIL t2_m1_next: got %b want %b", st(), 6'b10_1010);
        end
        checks++;
        if ({m0_if.rdata, m1_if.rdata} !== {32'h0, 32'h1234_5678}) begin
            errors++;
            $display("FAIL t2_rdata: got %h want %h",
                {m0_if.rdata, m1_if.rdata}, {32'h0, 32'h1234_5678});
        end
        checks++;
        if (s_if.addr !== 32'h8000_0004) begin
            errors++;
            $display("FAIL t2_addr: got %h want %h", s_if.addr, 32'h8000_0004);
        end
        tick();
        m1_if.valid = 1'b0;
        #1;
        checks++;
        if (st() !== 6'b00_0000) begin
            errors++;
            $display("FAIL t2_idle: got %b want %b", st(), 6'b00_0000);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        tick();
        m0_if.valid = 1'b1;
        m1_if.valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            #1;
            exp = (k % 2 == 0) ? 6'b01_1100 : 6'b10_1010;
            checks++;
            if (st() !== exp) begin
                errors++;
                $display("FAIL t3_alt%0d: got %b want %b", k, st(), exp);
            end
            if (k == 5) m0_if.valid = 1'b0;
        end
        tick();
        m1_if.valid = 1'b0;
        #1;
        checks++;
        if (st() !== 6'b00_0000) begin
            errors++;
            $display("FAIL t3_idle: got %b want %b", st(), 6'b00_0000);
        end
    endtask

    task automatic test_timeout();
        slave_en = 1'b0;
        tick();
        m0_if.valid = 1'b1;
        m0_if.addr  = 32'h8000_0010;
        m0_if.wstrb = 4'h0;
        for (int i = 0; i < 16; i++) begin
            tick();
            #1;
            checks++;
            if (st() !== 6'b01_1000) begin
                errors++;
                $display("FAIL t4_wait%0d: got %b want %b", i, st(), 6'b01_1000);
            end
        end
        tick();
        #1;
        checks++;
        if (st() !== 6'b01_0101) begin
            errors++;
            $display("FAIL t4_timeout: got %b want %b", st(), 6'b01_0101);
        end
        checks++;
        if (m0_if.rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL t4_err_rdata: got %h want %h",
                m0_if.rdata, 32'hDEAD_BEEF);
        end
        tick();
        m0_if.valid = 1'b0;
        #1;
        checks++;
        if (st() !== 6'b00_0000) begin
            errors++;
            $display("FAIL t4_after: got %b want %b", st(), 6'b00_0000);
        end
        slave_en    = 1'b1;
        slave_rdata = 32'h0BAD_F00D;
        tick();
        m0_if.valid = 1'b1;
        tick();
        #1;
        checks++;
        if (st() !== 6'b01_1100) begin
            errors++;
            $display("FAIL t4_recover: got %b want %b", st(), 6'b01_1100);
        end
        checks++;
        if (m0_if.rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL t4_recover_rdata: got %h want %h",
                m0_if.rdata, 32'h0BAD_F00D);
        end
        tick();
        m0_if.valid = 1'b0;
    endtask

    task automatic test_slave_stall();
        slave_en = 1'b0;
        tick();
        m0_if.valid = 1'b1;
        m0_if.addr  = 32'h0000_0100;
        m1_if.valid = 1'b1;
        m1_if.addr  = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if ({st(), s_if.addr} !== {6'b01_1000, 32'h0000_0100}) begin
                errors++;
                $display("FAIL t5_hold%0d: got %b/%h want %b/%h", i,
                    st(), s_if.addr, 6'b01_1000, 32'h0000_0100);
            end
        end
        tick();
        slave_en = 1'b1;
        #1;
        checks++;
        if ({st(), s_if.addr} !== {6'b01_1100, 32'h0000_0100}) begin
            errors++;
            $display("FAIL t5_done: got %b/%h want %b/%h",
                st(), s_if.addr, 6'b01_1100, 32'h0000_0100);
        end
        tick();
        m0_if.valid = 1'b0;
        #1;
        checks++;
        if ({st(), s_if.addr} !== {6'b10_1010, 32'h0000_0200}) begin
            errors++;
            $display("FAIL t5_m1: got %b/%h want %b/%h",
                st(), s_if.addr, 6'b10_1010, 32'h0000_0200);
        end
        tick();
        m1_if.valid = 1'b0;
        #1;
        checks++;
        if (st() !== 6'b00_0000) begin
            errors++;
            $display("FAIL t5_idle: got %b want %b", st(), 6'b00_0000);
        end
    endtask

    task automatic test_async_reset();
        slave_en = 1'b0;
        tick();
        m0_if.valid = 1'b1;
        tick();
        #1;
        checks++;
        if (st() !== 6'b01_1000) begin
            errors++;
            $display("FAIL t6_pre: got %b want %b", st(), 6'b01_1000);
        end
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (st() !== 6'b00_0000) begin
            errors++;
            $display("FAIL t6_async: got %b want %b", st(), 6'b00_0000);
        end
        tick();
        tick();
        resetn      = 1'b1;
        slave_en    = 1'b1;
        m1_if.valid = 1'b1;
        #1;
        checks++;
        if (st() !== 6'b00_0000) begin
            errors++;
            $display("FAIL t6_idle: got %b want %b", st(), 6'b00_0000);
        end
        tick();
        #1;
        checks++;
        if (st() !== 6'b01_1100) begin
            errors++;
            $display("FAIL t6_m0_wins: got %b want %b", st(), 6'b01_1100);
        end
        tick();
        m0_if.valid = 1'b0;
        #1;
        checks++;
        if (st() !== 6'b10_1010) begin
            errors++;
            $display("FAIL t6_m1: got %b want %b", st(), 6'b10_1010);
        end
        tick();
        m1_if.valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_reset();
        test_tie_break();
        test_back_to_back();
        test_timeout();
        test_reset();
        test_slave_stall();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pico_bus_arbiter2.md
Name: pico_bus_arbiter2

Overview:
Two-master, one-slave arbiter for the PicoRV32 native memory bus (valid/ready, addr, wdata, wstrb, rdata). It shares one peripheral slave, such as the GPIO block, between the CPU (m0) and a second master (m1, a DMA or debug port). Arbitration is round-robin, the grant is held for the full transaction, and a bus timeout completes a transaction to a silent slave.

Parameters:
TIMEOUT, 16, grant cycles the slave gets to assert s_ready before the arbiter completes the transaction itself; 0 disables the timeout.
ERR_RDATA, 32'hDEAD_BEEF, read data returned to the master on a timeout.

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
m0_valid  input  1  master 0 request, held until m0_ready
m0_addr  input  32  master 0 address
m0_wdata  input  32  master 0 write data
m0_wstrb  input  4  master 0 byte strobes, 0 = read
m0_ready  output  1  master 0 transaction complete, one-cycle pulse
m0_rdata  output  32  master 0 read data, valid with m0_ready
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  (same directions and widths)  master 1, identical semantics
s_valid  output  1  request to slave
s_addr  output  32  address to slave
s_wdata  output  32  write data to slave
s_wstrb  output  4  strobes to slave
s_ready  input  1  slave complete; may be combinational in s_valid
s_rdata  input  32  slave read data
gnt  output  2  one-hot current grant, 00 when idle
timeout_err  output  1  one-cycle pulse on a timeout completion

Behaviour:
- Clocking and reset: one clock domain. resetn is asynchronous and active-low.
- Reset values: state=IDLE, gnt=00, last=1 (so m0 wins the first tie), cnt=0. All outputs are 0: s_valid, s_addr, s_wdata, s_wstrb, m*_ready, m*_rdata, timeout_err.
- States: IDLE, GNT0, GNT1. gnt is a decode of the state register.
- IDLE:
  - m0_valid only -> GNT0; m1_valid only -> GNT1.
  - Both valid -> grant the master not equal to last.
  - s_valid=0 in IDLE, so grant latency is 1 cycle from request to s_valid.
- GNTx:
  - s_valid = mx_valid; s_addr/s_wdata/s_wstrb are muxed from mx combinationally. Slave-side outputs are 0 when not granted.
  - s_ready=1 while s_valid=1 -> mx_ready=1 and mx_rdata=s_rdata in the same cycle; last<=x; cnt<=0.
  - On that completion, next state is GNTy if my_valid=1, else IDLE. Back-to-back alternation therefore has no dead cycle.
  - The master that just completed cannot be regranted without passing through IDLE or the other grant. It only wins in IDLE if it is the sole requester.
- Timeout (TIMEOUT>0):
  - cnt increments on each GNTx cycle without s_ready, so the slave sees up to TIMEOUT cycles of s_valid.
  - In the cycle where cnt==TIMEOUT: s_valid=0, mx_ready=1, mx_rdata=ERR_RDATA, timeout_err=1.
  - The state then transitions exactly as for a normal completion.
  - cnt width is $clog2(TIMEOUT+1); it saturates and never wraps.
- Granted master drops valid before ready (protocol violation): s_valid follows it to 0 that cycle, the arbiter returns to IDLE next cycle, cnt<=0, and no ready is issued.
- Ready/rdata isolation: a master that is not granted always sees ready=0 and rdata=0. s_ready while in IDLE is ignored.
- Reset mid-transaction: everything clears immediately and asynchronously. No completion is reported to the master.

Test Plan:
1. Reset, then m0 write addr 0x8000_0008, wdata 0x0000_00A5, wstrb 4'hF, with the slave ready in the same cycle as s_valid -> s_valid 1 cycle after m0_valid; s_* equal m0 values; m0_ready 1 cycle wide; gnt 01 -> 00; m1_ready stays 0.
2. m0 and m1 both assert reads on the same cycle after reset -> m0 served first. Then m1 is granted on the cycle after m0_ready, with no idle gap. m1_rdata equals the slave value (e.g. 0x1234_5678) and m0_rdata=0 in that cycle.
3. Both masters request continuously for 6 transactions -> strict alternation m0, m1, m0, m1, m0, m1; each ready pulse goes only to the granted master.
4. Slave never asserts ready, TIMEOUT=16 -> s_valid high for 16 cycles, then one cycle with s_valid=0, m0_ready=1, m0_rdata=0xDEAD_BEEF, timeout_err=1. A subsequent request with a responsive slave completes normally.
5. Slave delays ready by 3 cycles while m1 waits -> m0 grant held 4 cycles, m1 s_addr never visible during m0's grant, m1 granted immediately after.
6. Assert resetn=0 mid-grant while the slave is stalled -> s_valid, gnt and m*_ready are 0 asynchronously. After release, m0 wins a simultaneous request.
